// File: rtl/magnetron_pkg.sv
// Shared definitions for the magnetron controller: state encoding and
// parameter-derived sizes used by the top level and the prescaler.
package magnetron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int pw_bits(input int levels);
    return $clog2(levels + 1);
  endfunction

  function automatic int slot_len(input int ticks, input int levels);
    return ticks / levels;
  endfunction

  // Every second must split into whole power slots.
  function automatic bit params_legal(input int ticks, input int levels);
    return (ticks >= 2) && (levels >= 1) && ((ticks % levels) == 0);
  endfunction

endpackage

// File: rtl/magnetron_prescaler.sv
// Per-second tick counter split into power slots; sec_tick flags the last
// cycle of each second whether or not the counter is held.
module magnetron_prescaler #(
  parameter int PWR_LEVELS = 10,
  parameter int SLOT_LEN   = 100,
  parameter int PW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          hold,
  output logic          sec_tick,
  output logic [PW-1:0] slot_idx
);

  localparam int SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [SW-1:0] SUB_LAST  = SW'(SLOT_LEN - 1);
  localparam logic [PW-1:0] SLOT_LAST = PW'(PWR_LEVELS - 1);

  logic [SW-1:0] sub_q, sub_d;
  logic [PW-1:0] slot_q, slot_d;
  logic          slot_end;

  always_comb begin
    slot_end = (sub_q == SUB_LAST);
    sec_tick = slot_end && (slot_q == SLOT_LAST);
    sub_d    = sub_q;
    slot_d   = slot_q;
    if (clr) begin
      sub_d  = '0;
      slot_d = '0;
    end else if (!hold) begin
      if (slot_end) begin
        sub_d  = '0;
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + PW'(1);
      end else begin
        sub_d = sub_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q  <= '0;
      slot_q <= '0;
    end else begin
      sub_q  <= sub_d;
      slot_q <= slot_d;
    end
  end

  assign slot_idx = slot_q;

endmodule

// File: rtl/magnetron_ctrl.sv
// Microwave magnetron controller: key edge detect, cook/pause/done FSM,
// seconds countdown, duty-cycle power slotting and door interlock.
module magnetron_ctrl
  import magnetron_pkg::*;
#(
  parameter int TIME_W        = 12,
  parameter int TICKS_PER_SEC = 1000,
  parameter int PWR_LEVELS    = 10,
  parameter int BEEP_SEC      = 3,
  localparam int PW           = pw_bits(PWR_LEVELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              door_closed,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              time_load_en,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PW-1:0]     power_level,
  output logic              magnetron_on,
  output logic [TIME_W-1:0] remaining,
  output logic [1:0]        state,
  output logic              done_pulse,
  output logic              beep
);

  localparam int SLOT_LEN = slot_len(TICKS_PER_SEC, PWR_LEVELS);
  localparam int BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC + 1) : 1;
  localparam logic [PW-1:0] PWR_MAX   = PW'(PWR_LEVELS);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);

  if (!params_legal(TICKS_PER_SEC, PWR_LEVELS)) begin : g_param_check
    $error("magnetron_ctrl: TICKS_PER_SEC must be >= 2 and a multiple of PWR_LEVELS");
  end

  state_e            state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [PW-1:0]     pwr_q, pwr_d;
  logic [BW-1:0]     beep_cnt_q, beep_cnt_d;
  logic              done_q, done_d;
  logic              start_prev_q, stop_prev_q, clear_prev_q;

  logic          start_p, stop_p, clear_p;
  logic          cook, running, pause_req;
  logic          raw_tick, sec_tick, pre_clr, pre_hold;
  logic [PW-1:0] slot_idx;

  assign start_p = start_prev_q & ~startn;
  assign stop_p  = stop_prev_q  & ~stopn;
  assign clear_p = clear_prev_q & ~clearn;

  assign cook      = (state_q == ST_COOK);
  assign running   = cook || (state_q == ST_DONE);
  assign sec_tick  = raw_tick && running;
  assign pause_req = cook && (stop_p || !door_closed);
  // Freeze the phase on the cycle we leave COOK so resume continues where the
  // drive stopped; a second boundary still wraps so it is never counted twice.
  assign pre_hold  = !running || (pause_req && !raw_tick);

  magnetron_prescaler #(
    .PWR_LEVELS(PWR_LEVELS),
    .SLOT_LEN  (SLOT_LEN),
    .PW        (PW)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clr     (pre_clr),
    .hold    (pre_hold),
    .sec_tick(raw_tick),
    .slot_idx(slot_idx)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pwr_d      = pwr_q;
    beep_cnt_d = beep_cnt_q;
    done_d     = 1'b0;
    pre_clr    = 1'b0;
    if (clear_p) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p) begin
            if (door_closed && (rem_q != '0)) begin
              state_d = ST_COOK;
              pwr_d   = (power_level > PWR_MAX) ? PWR_MAX : power_level;
              pre_clr = 1'b1;
            end
          end else if (!stop_p && time_load_en) begin
            rem_d = time_in;
          end
        end
        ST_COOK: begin
          if (sec_tick && (rem_q != '0)) rem_d = rem_q - TIME_W'(1);
          if (sec_tick && (rem_q == TIME_W'(1))) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            beep_cnt_d = '0;
          end else if (pause_req) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (stop_p) state_d = ST_IDLE;
          else if (start_p && door_closed) state_d = ST_COOK;
        end
        ST_DONE: begin
          if (start_p || stop_p) begin
            state_d = ST_IDLE;
          end else if (time_load_en) begin
            state_d = ST_IDLE;
            rem_d   = time_in;
          end else if (sec_tick) begin
            if (beep_cnt_q == BEEP_LAST) state_d = ST_IDLE;
            else beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      pwr_q        <= '0;
      beep_cnt_q   <= '0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      pwr_q        <= pwr_d;
      beep_cnt_q   <= beep_cnt_d;
      done_q       <= done_d;
      start_prev_q <= startn;
      stop_prev_q  <= stopn;
      clear_prev_q <= clearn;
    end
  end

  // Door gate is deliberately combinational so the drive drops immediately.
  assign magnetron_on = cook & (slot_idx < pwr_q) & door_closed;
  assign remaining    = rem_q;
  assign state        = state_q;
  assign done_pulse   = done_q;
  assign beep         = (state_q == ST_DONE);

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed and randomized bench for magnetron_ctrl, checked every cycle
// against a phase-counting behavioural model of the oven.
module tb_magnetron_ctrl;

  localparam int TIME_W = 8;
  localparam int TICKS  = 10;
  localparam int LEVELS = 5;
  localparam int BEEP   = 2;
  localparam int PW     = 3;
  localparam int SLOT   = TICKS / LEVELS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              door_closed = 1'b1;
  logic              startn = 1'b1;
  logic              stopn = 1'b1;
  logic              clearn = 1'b1;
  logic              time_load_en = 1'b0;
  logic [TIME_W-1:0] time_in = '0;
  logic [PW-1:0]     power_level = '0;
  logic              magnetron_on;
  logic [TIME_W-1:0] remaining;
  logic [1:0]        state;
  logic              done_pulse;
  logic              beep;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model: state as 0..3, seconds left, latched power, cook phase within second.
  int m_state, m_rem, m_pwr, m_phase, m_beep_secs;
  bit m_done, m_prev_start, m_prev_stop, m_prev_clear;

  int on_cnt, done_cnt, beep_cnt;
  int last_rem, last_state;
  logic last_on;

  always #5 clk = ~clk;

  magnetron_ctrl #(
    .TIME_W       (TIME_W),
    .TICKS_PER_SEC(TICKS),
    .PWR_LEVELS   (LEVELS),
    .BEEP_SEC     (BEEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .door_closed (door_closed),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .time_load_en(time_load_en),
    .time_in     (time_in),
    .power_level (power_level),
    .magnetron_on(magnetron_on),
    .remaining   (remaining),
    .state       (state),
    .done_pulse  (done_pulse),
    .beep        (beep)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_on();
    return (m_state == 1) && door_closed && ((m_phase / SLOT) < m_pwr);
  endfunction

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_pwr = 0; m_phase = 0; m_beep_secs = 0;
    m_done = 0; m_prev_start = 1; m_prev_stop = 1; m_prev_clear = 1;
  endtask

  task automatic model_edge();
    bit sp, tp, cp, tick, leaving;
    if (rst) begin
      model_reset();
      return;
    end
    tp = m_prev_start && !startn;
    sp = m_prev_stop && !stopn;
    cp = m_prev_clear && !clearn;
    m_prev_start = startn; m_prev_stop = stopn; m_prev_clear = clearn;
    m_done = 0;
    tick = (m_phase == TICKS - 1);
    if (cp) begin
      m_state = 0; m_rem = 0;
    end else begin
      case (m_state)
        0: begin
          if (tp) begin
            if (door_closed && m_rem != 0) begin
              m_state = 1; m_phase = 0;
              m_pwr = (int'(power_level) > LEVELS) ? LEVELS : int'(power_level);
            end
          end else if (!sp && time_load_en) m_rem = int'(time_in);
        end
        1: begin
          leaving = sp || !door_closed;
          if (tick || !leaving) m_phase = (m_phase + 1) % TICKS;
          if (tick) m_rem--;
          if (tick && m_rem == 0) begin
            m_state = 3; m_done = 1; m_beep_secs = 0;
          end else if (leaving) m_state = 2;
        end
        2: begin
          if (sp) m_state = 0;
          else if (tp && door_closed) m_state = 1;
        end
        default: begin
          m_phase = (m_phase + 1) % TICKS;
          if (tp || sp) m_state = 0;
          else if (time_load_en) begin
            m_state = 0; m_rem = int'(time_in);
          end else if (tick) begin
            m_beep_secs++;
            if (m_beep_secs == BEEP) m_state = 0;
          end
        end
      endcase
    end
  endtask

  // Check this cycle's outputs, advance the model, then step to just past the edge.
  task automatic cyc();
    #2;
    chk("state", state, m_state);
    chk("remaining", remaining, m_rem);
    chk("magnetron_on", magnetron_on, exp_on());
    chk("done_pulse", done_pulse, m_done);
    chk("beep", beep, m_state == 3);
    last_on = magnetron_on;
    last_rem = int'(remaining);
    last_state = int'(state);
    on_cnt += int'(magnetron_on);
    done_cnt += int'(done_pulse);
    beep_cnt += int'(beep);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    time_in = TIME_W'(v); time_load_en = 1'b1; cyc(); time_load_en = 1'b0;
  endtask
  task automatic press_start(); startn = 1'b0; cyc(); startn = 1'b1; endtask
  task automatic press_stop();  stopn  = 1'b0; cyc(); stopn  = 1'b1; endtask
  task automatic press_clear(); clearn = 1'b0; cyc(); clearn = 1'b1; endtask
  task automatic clr_counts(); on_cnt = 0; done_cnt = 0; beep_cnt = 0; endtask

  initial begin
    int p, t, found;
    logic [9:0] pat;
    model_reset();
    clr_counts();
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
    $display("txn reset: state=%0d remaining=%0d", state, remaining);

    // Basic cook: full power, 3 seconds, then 2 seconds of beep.
    power_level = 3'd5;
    load(3);
    press_start();
    clr_counts();
    for (int i = 0; i < 55; i++) begin
      cyc();
      if (i == 10) chk("basic_rem_c10", last_rem, 2);
      if (i == 20) chk("basic_rem_c20", last_rem, 1);
      if (i == 30) chk("basic_rem_c30", last_rem, 0);
    end
    chk("basic_on_cycles", on_cnt, 30);
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_beep_cycles", beep_cnt, 20);
    $display("txn basic: on=%0d done=%0d beep=%0d", on_cnt, done_cnt, beep_cnt);

    // Duty cycle at power 2: on for cycles 0..3 of each second.
    power_level = 3'd2;
    load(2);
    press_start();
    clr_counts();
    pat = '0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i < 10) pat[i] = last_on;
    end
    chk("duty_pattern", pat, 10'b0000001111);
    chk("duty_on_cycles", on_cnt, 8);
    repeat (25) cyc();
    $display("txn duty: pattern=%b on=%0d", pat, on_cnt);

    // Random power levels, including values that must saturate.
    for (int k = 0; k < 3; k++) begin
      p = int'($urandom_range(0, 7));
      t = int'($urandom_range(1, 3));
      power_level = PW'(p);
      load(t);
      press_start();
      clr_counts();
      repeat (t * TICKS + 25) cyc();
      chk("rand_duty_on", on_cnt, t * SLOT * ((p > LEVELS) ? LEVELS : p));
      $display("txn rand_power: p=%0d t=%0d on=%0d", p, t, on_cnt);
    end

    // Door interlock: open 5 cycles into COOK, then resume.
    power_level = 3'd5;
    load(4);
    press_start();
    repeat (5) cyc();
    door_closed = 1'b0;
    cyc();
    chk("door_drop_same_cycle", last_on, 0);
    cyc();
    chk("door_pause", last_state, 2);
    repeat (3) cyc();
    door_closed = 1'b1;
    repeat (2) cyc();
    press_start();
    found = -1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (found < 0 && last_rem != 4) found = i;
    end
    chk("resume_decrement_cycle", found, 5);
    press_clear();
    cyc();
    $display("txn door: resume decrement at cycle %0d", found);

    // Stop / stop / clear / start-with-zero.
    power_level = 3'd3;
    load(6);
    press_start();
    repeat (13) cyc();
    press_stop();
    cyc();
    chk("stop_to_pause", last_state, 2);
    press_stop();
    cyc();
    chk("stop_to_idle", last_state, 0);
    chk("stop_keeps_rem", last_rem, 5);
    press_clear();
    cyc();
    chk("clear_rem", last_rem, 0);
    press_start();
    cyc();
    chk("start_zero_idle", last_state, 0);
    $display("txn stop_clear: state=%0d remaining=%0d", last_state, last_rem);

    // Clear and start in the same cycle.
    load(5);
    startn = 1'b0; clearn = 1'b0;
    cyc();
    startn = 1'b1; clearn = 1'b1;
    cyc();
    chk("prio_state", last_state, 0);
    chk("prio_rem", last_rem, 0);
    $display("txn priority: state=%0d remaining=%0d", last_state, last_rem);

    // Reset mid-cook.
    power_level = 3'd4;
    load(7);
    press_start();
    repeat ($urandom_range(3, 25)) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_state", last_state, 0);
    chk("rst_rem", last_rem, 0);
    chk("rst_on", last_on, 0);
    $display("txn reset_mid_cook: state=%0d remaining=%0d", last_state, last_rem);

    // Power 0: timer completes, drive never on.
    power_level = 3'd0;
    load(2);
    press_start();
    clr_counts();
    repeat (45) cyc();
    chk("pwr0_on_cycles", on_cnt, 0);
    chk("pwr0_done_pulses", done_cnt, 1);
    $display("txn power0: on=%0d done=%0d", on_cnt, done_cnt);

    // Random soak.
    for (int i = 0; i < 400; i++) begin
      door_closed  = ($urandom_range(0, 19) != 0);
      startn       = ($urandom_range(0, 7) != 0);
      stopn        = ($urandom_range(0, 14) != 0);
      clearn       = ($urandom_range(0, 39) != 0);
      time_load_en = ($urandom_range(0, 9) == 0);
      time_in      = ($urandom_range(0, 19) == 0) ? TIME_W'(200) : TIME_W'($urandom_range(0, 4));
      power_level  = PW'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; time_load_en = 1'b0;
    $display("txn soak: %0d checks so far", n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
